// File: rtl/gen_arb_pkg.sv
// -----------------------------------------------------------------------------
// gen_arb_pkg
// Shared definitions for the gen_op_arbiter slice:
//   - op-code encodings for the shared half-adder/logic array
//   - FSM state encoding for the arbiter/sequencer
//   - onehot() helper used to build grant and done vectors
// -----------------------------------------------------------------------------
package gen_arb_pkg;

    // Largest supported requester count; onehot() is sized for it.
    localparam int MAX_R = 8;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_HA  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [MAX_R-1:0] onehot(input logic [2:0] idx);
        logic [MAX_R-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/gen_op_arbiter_ha_logic_unit.sv
// -----------------------------------------------------------------------------
// ha_logic_unit
// Combinational N-bit array of per-bit half-adder/logic cells, one cell per bit
// built with a generate loop. The op code selects the cell function:
//   OP_AND : res = a & b           cout = 0
//   OP_OR  : res = a | b           cout = 0
//   OP_XOR : res = a ^ b           cout = 0
//   OP_HA  : res = a ^ b           cout = a & b   (per-bit half adder)
// Ports:
//   a_i, b_i [N-1:0]  operands
//   op_i     [1:0]    op code
//   res_o    [N-1:0]  per-bit result
//   cout_o   [N-1:0]  per-bit carry (HA only)
// -----------------------------------------------------------------------------
module ha_logic_unit
    import gen_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [1:0]   op_i,
    output logic [N-1:0] res_o,
    output logic [N-1:0] cout_o
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign res_o[i]  = (op_i == OP_AND) ? (a_i[i] & b_i[i]) :
                           (op_i == OP_OR)  ? (a_i[i] | b_i[i]) :
                                              (a_i[i] ^ b_i[i]);
        assign cout_o[i] = (op_i == OP_HA) & a_i[i] & b_i[i];
    end

endmodule

// File: rtl/gen_op_arbiter.sv
// -----------------------------------------------------------------------------
// gen_op_arbiter
// Round-robin arbiter/sequencer sharing one ha_logic_unit between R requesters.
// A winner is granted for one cycle (operands latched at the grant edge), the
// shared array is evaluated in EXEC, and the registered result is returned with
// a one-cycle done pulse in RESP.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req    [R-1:0]      request levels, sampled only at arbitration edges
//   op_in  [2R-1:0]     op code of requester i at [2i+1:2i]
//   a_in   [RN-1:0]     operand A of requester i at [Ni+N-1:Ni]
//   b_in   [RN-1:0]     operand B, same packing
//   gnt    [R-1:0]      one-hot grant pulse
//   done   [R-1:0]      one-hot result-valid pulse
//   res    [N-1:0]      registered result
//   cout_o [N-1:0]      registered per-bit carry (0 for non-HA ops)
//   busy                high whenever the FSM is not idle
//
// Build option: define GEN_ARB_BACK2BACK_EN to let RESP arbitrate and chain
// straight into the next EXEC (one transaction every 2 cycles instead of 3).
// -----------------------------------------------------------------------------
module gen_op_arbiter
    import gen_arb_pkg::*;
#(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [2*R-1:0] op_in,
    input  logic [R*N-1:0] a_in,
    input  logic [R*N-1:0] b_in,
    output logic [R-1:0]   gnt,
    output logic [R-1:0]   done,
    output logic [N-1:0]   res,
    output logic [N-1:0]   cout_o,
    output logic           busy
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q,   ptr_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [R-1:0]  gnt_q,   gnt_d;
    logic [R-1:0]  done_q,  done_d;
    logic [N-1:0]  res_q,   res_d;
    logic [N-1:0]  cout_q,  cout_d;

    logic [N-1:0]  a_q, b_q;
    logic [1:0]    op_q;
    logic          latch_en;

    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] arb_start;
    logic [IW-1:0] nxt_ptr;

    logic [N-1:0]  unit_res;
    logic [N-1:0]  unit_cout;

    // Pointer value after the current transaction: (idx+1) mod R.
    assign nxt_ptr   = (idx_q == IW'(R - 1)) ? '0 : idx_q + 1'b1;

    // RESP only arbitrates in the back-to-back build; it must already search
    // from the pointer it is about to commit.
    assign arb_start = (state_q == ST_RESP) ? nxt_ptr : ptr_q;

    // Round-robin search: first requester at or after arb_start, wrapping.
    always_comb begin : p_pick
        int j;
        j       = 0;
        win_vld = 1'b0;
        win_idx = arb_start;
        for (int k = 0; k < R; k++) begin
            j = (int'(arb_start) + k) % R;
            if (!win_vld && req[j]) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
            end
        end
    end

    ha_logic_unit #(.N(N)) u_unit (
        .a_i    (a_q),
        .b_i    (b_q),
        .op_i   (op_q),
        .res_o  (unit_res),
        .cout_o (unit_cout)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        gnt_d    = '0;
        done_d   = '0;
        res_d    = res_q;
        cout_d   = cout_q;
        latch_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d  = ST_EXEC;
                    gnt_d    = R'(onehot(3'(win_idx)));
                    idx_d    = win_idx;
                    latch_en = 1'b1;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                res_d   = unit_res;
                cout_d  = unit_cout;
                done_d  = R'(onehot(3'(idx_q)));
            end
            ST_RESP: begin
                ptr_d   = nxt_ptr;
`ifdef GEN_ARB_BACK2BACK_EN
                if (win_vld) begin
                    state_d  = ST_EXEC;
                    gnt_d    = R'(onehot(3'(win_idx)));
                    idx_d    = win_idx;
                    latch_en = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            res_q   <= '0;
            cout_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
        end
    end

    // Operand latches are pure data; their contents only matter after a grant.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            a_q  <= a_in[N*int'(win_idx) +: N];
            b_q  <= b_in[N*int'(win_idx) +: N];
            op_q <= op_in[2*int'(win_idx) +: 2];
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign res    = res_q;
    assign cout_o = cout_q;
    assign busy   = (state_q != ST_IDLE);

endmodule
